// File: rtl/coin_pkg.sv
// Shared constants and helpers for the coin input conditioner slice.
package coin_pkg;

  localparam int unsigned COIN_VAL5        = 5;
  localparam int unsigned COIN_VAL10       = 10;
  localparam int unsigned TOTAL_W          = 8;
  localparam int unsigned TOTAL_MAX        = 255;
  localparam int unsigned DEBOUNCE_DEFAULT = 4;

  // Saturating add; relies on TOTAL_MAX being the all-ones value of TOTAL_W bits.
  function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] a,
                                                 input logic [TOTAL_W-1:0] b);
    logic [TOTAL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[TOTAL_W] ? TOTAL_W'(TOTAL_MAX) : s[TOTAL_W-1:0];
  endfunction

endpackage

// File: rtl/coin_input_conditioner_debounce.sv
// One coin channel: 2-FF synchronizer, debounce counter, debounced level and
// a single-cycle pulse on each rising edge of the debounced level.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic edge_pulse
);

  localparam int unsigned          CNT_W    = 8;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_deb;
  logic             r_deb_d;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta  <= raw;
      r_sync  <= r_meta;
      r_deb_d <= r_deb;
      // Any agreeing sample restarts the stability count.
      if (r_sync == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_deb <= r_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign edge_pulse = r_deb & ~r_deb_d;

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin sensor front end: debounces both channels, arbitrates in5/in10, rejects
// coins while disabled. Optional saturating total under `COIN_TOTAL_EN.
module coin_input_conditioner
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic coin5_raw,
  input  logic coin10_raw,
  input  logic accept_en,
  output logic in5,
  output logic in10,
  output logic reject
`ifdef COIN_TOTAL_EN
  ,
  output logic [TOTAL_W-1:0] total,
  input  logic               total_clr
`endif
);

  logic w_e5;
  logic w_e10;
  logic r_in5;
  logic r_in10;
  logic r_reject;
  logic r_pend10;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (coin5_raw),
    .edge_pulse (w_e5)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (coin10_raw),
    .edge_pulse (w_e10)
  );

  // Simultaneous accepted coins: in5 now, in10 deferred one cycle via r_pend10.
  // A re-edge needs 2*DEBOUNCE_CYCLES cycles, so r_pend10 never collides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in5    <= 1'b0;
      r_in10   <= 1'b0;
      r_reject <= 1'b0;
      r_pend10 <= 1'b0;
    end else begin
      r_in5    <= accept_en & w_e5;
      r_in10   <= r_pend10 | (accept_en & w_e10 & ~w_e5);
      r_pend10 <= accept_en & w_e5 & w_e10;
      r_reject <= ~accept_en & (w_e5 | w_e10);
    end
  end

  assign in5    = r_in5;
  assign in10   = r_in10;
  assign reject = r_reject;

`ifdef COIN_TOTAL_EN
  logic [TOTAL_W-1:0] r_total;
  logic [TOTAL_W-1:0] w_add;

  assign w_add = r_in10 ? TOTAL_W'(COIN_VAL10) :
                 r_in5  ? TOTAL_W'(COIN_VAL5)  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total <= '0;
    end else if (total_clr) begin
      r_total <= '0;
    end else begin
      r_total <= sat_add(r_total, w_add);
    end
  end

  assign total = r_total;
`endif

endmodule

// File: doc/coin_input_conditioner.md
# coin_input_conditioner

Upstream front end for `vending_fsm`. It takes the two raw, asynchronous, bouncy coin-sensor lines and converts them into clean, synchronous, single-cycle `in5`/`in10` pulses that the FSM consumes directly. It also arbitrates simultaneous coins and rejects coins while acceptance is disabled.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required before a level change is accepted. Legal range 2..255.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `coin5_raw` input 1: raw 5-unit coin sensor, asynchronous to `clk`, active-high, may bounce.
- `coin10_raw` input 1: raw 10-unit coin sensor, with the same properties as `coin5_raw`.
- `accept_en` input 1: when high, coins are forwarded; when low, coins are rejected.
- `in5` output 1: one-cycle pulse per accepted 5-unit coin; drives `vending_fsm.in5`.
- `in10` output 1: one-cycle pulse per accepted 10-unit coin; drives `vending_fsm.in10`.
- `reject` output 1: one-cycle pulse per coin detected while `accept_en` is low.
- `total` output 8: accumulated accepted value. Present only under `COIN_TOTAL_EN`.
- `total_clr` input 1: synchronous clear of `total`. Present only under `COIN_TOTAL_EN`.

## Operation
- Per channel, the input path is:
  - A 2-FF synchronizer produces `sync`.
  - A debounce counter and a debounced level `deb` follow.
  - A rising-edge detect on `deb` produces `edge`.
- Debounce rules:
  - The counter increments each cycle `sync != deb`.
  - The counter clears to 0 on any cycle `sync == deb`.
  - When the counter equals `DEBOUNCE_CYCLES-1` and `sync != deb` still holds, `deb` takes `sync` and the counter clears.
  - Glitches shorter than `DEBOUNCE_CYCLES` cycles produce no event.
- Only rising edges of `deb` count as coins. A falling `deb` is silent.
- Dispatch of `edge`, registered:
  - `accept_en` is sampled in the same cycle as `edge`.
  - If `accept_en` is low, `reject` pulses and no `in5`/`in10` is issued.
  - If `accept_en` is high, the coin goes to the output arbiter.
- Output arbiter:
  - At most one of `in5`/`in10` is high in any cycle.
  - A 5-edge and a 10-edge accepted in the same cycle: `in5` is emitted first.
  - The 10-unit coin is then held in a `pend10` flag and emitted as `in10` on the next cycle.
  - A `pend10` coin always emits, even if `accept_en` falls in between.
  - Pending overflow cannot occur, because a debounced re-edge needs ≥ 2·`DEBOUNCE_CYCLES` cycles.
- Two coins seen in the same cycle while rejected produce a single `reject` pulse.
- Reset (`rst_n` low) takes effect immediately:
  - Synchronizers, counters and `deb` clear to 0, so a sensor held high at reset release is seen as a new coin after debounce.
  - `pend10` clears, and any pending coin is lost.
  - Outputs return to their reset values.

## Timing
- Reset values: `in5`=0, `in10`=0, `reject`=0, `total`=0.
- Latency is counted from the first rising edge E0 at which a raw line is sampled high and then stays high:
  - `deb` rises at E0+`DEBOUNCE_CYCLES`+1.
  - The `in5`/`in10`/`reject` pulse is high for exactly one cycle, starting at edge E0+`DEBOUNCE_CYCLES`+2 (E0+6 with the default).
- A deferred `in10` from simultaneous arrival goes high one cycle later, at E0+`DEBOUNCE_CYCLES`+3.
- Minimum spacing between same-channel pulses is 2·`DEBOUNCE_CYCLES` cycles.
- No handshake: the FSM samples every cycle and needs no back-pressure.

## Configuration
- Macro `COIN_TOTAL_EN`.
- Defined: adds the `total` and `total_clr` ports.
  - `total` is a saturating accumulator: +5 on each `in5` pulse, +10 on each `in10` pulse, clamped at 255 (for example, 250 + 10 gives 255).
  - `total_clr` zeroes `total` at the next edge and takes priority over a same-cycle add.
- Undefined: the ports and the accumulator are absent; all other behaviour is identical.

## Structure
- Package `coin_pkg`:
  - Constants `COIN_VAL5`=5, `COIN_VAL10`=10, `TOTAL_W`=8, `TOTAL_MAX`=255.
  - Default `DEBOUNCE_CYCLES`.
- Sub-module `coin_debounce`: synchronizer, debounce counter, `deb` level and rising-edge pulse for one channel.
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `rst_n`, `raw`, `edge_pulse`.
  - The top level instantiates it twice and holds the accept/reject logic, the arbiter, `pend10` and the optional accumulator.

## Test plan
- Reset and single coin:
  - Stimulus: hold `rst_n` low for 2 cycles with all outputs checked, then release. `accept_en`=1; `coin5_raw` high at E0 for 20 cycles.
  - Required: `in5` high for exactly one cycle at E0+6; `in10`=`reject`=0 throughout.
- Bounce rejection: toggle `coin10_raw` high/low every 2 cycles for 12 cycles, then hold high → exactly one `in10` pulse, 6 cycles after the hold begins.
- Simultaneous coins: both raw lines rise at the same edge → `in5` at E0+6 and `in10` at E0+7; never both high.
- Acceptance disabled:
  - Stimulus: `accept_en`=0, one 10-coin.
  - Required: `reject` for one cycle at E0+6, no `in10`. Repeat with `accept_en`=1 and get `in10`.
- Reset mid-operation: assert `rst_n` low at E0+3 while `coin5_raw` is held high, release at E0+5 → no pulse before release; `in5` at release+6.
- With `COIN_TOTAL_EN`:
  - Stimulus: 5+10+10 accepted coins.
  - Required: `total`=25; after 26 more 10-coins `total`=255; `total_clr` sets it to 0 on the next edge.
